// File: rtl/mat_stream_host.sv
// mat_stream_host: host-side stream engine for the matrix-multiply accelerator.
// Holds operands A/B in local RAM, streams them out on m00_axis with sel
// marking the matrix, pulses start, then captures the result stream from
// s00_axis into a result RAM exposed through a registered readback port.
// Optional build macro: MAT_HOST_TLAST_CHECK_EN adds a sticky result-stream
// framing check on s00_axis_tlast (tlast_err); without it tlast_err is 0.
module mat_stream_host #(
  parameter int unsigned DIM_LOG    = 1,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned DIM       = 1 << DIM_LOG,
  localparam int unsigned SIZE      = DIM * DIM,
  localparam int unsigned SIZE_LOG  = 2 * DIM_LOG
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_areset,
  input  logic                    load_we,
  input  logic                    load_sel,
  input  logic [SIZE_LOG-1:0]     load_addr,
  input  logic [DATA_WIDTH-1:0]   load_data,
  input  logic                    go,
  output logic                    busy,
  output logic                    done,
  output logic                    tlast_err,
  output logic                    m00_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                    m00_axis_tlast,
  input  logic                    m00_axis_tready,
  output logic                    sel,
  output logic                    start,
  output logic                    s00_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic                    s00_axis_tlast,
  input  logic                    s00_axis_tvalid,
  input  logic [SIZE_LOG-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam logic [SIZE_LOG-1:0] LAST_IDX = SIZE_LOG'(SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    START,
    RECV,
    DONE
  } state_t;

  state_t                  state, state_n;
  logic [SIZE_LOG-1:0]     tx_idx, tx_idx_n, tx_nxt;
  logic [SIZE_LOG-1:0]     rx_idx, rx_idx_n;
  logic                    busy_n, done_n, tvalid_n, tlast_n, sel_n, start_n, s_tready_n;
  logic [DATA_WIDTH-1:0]   tdata_n;
  logic                    tx_hs_c;
  logic                    rx_we_c;

  logic [DATA_WIDTH-1:0]   mem_a [SIZE];
  logic [DATA_WIDTH-1:0]   mem_b [SIZE];
  logic [DATA_WIDTH-1:0]   mem_r [SIZE];

`ifdef MAT_HOST_TLAST_CHECK_EN
  logic                    tlast_err_n;
`else
  logic                    unused_tlast;
  assign unused_tlast = s00_axis_tlast;
  assign tlast_err    = 1'b0;
`endif

  assign m00_axis_tstrb = '1;
  assign tx_hs_c        = m00_axis_tvalid && m00_axis_tready;
  assign tx_nxt         = tx_idx + SIZE_LOG'(1);

  // Next-state and next-output logic; every register holds unless a branch moves it.
  always_comb begin
    state_n    = state;
    tx_idx_n   = tx_idx;
    rx_idx_n   = rx_idx;
    busy_n     = busy;
    done_n     = 1'b0;
    start_n    = 1'b0;
    tvalid_n   = m00_axis_tvalid;
    tdata_n    = m00_axis_tdata;
    tlast_n    = m00_axis_tlast;
    sel_n      = sel;
    s_tready_n = s00_axis_tready;
    rx_we_c    = 1'b0;
`ifdef MAT_HOST_TLAST_CHECK_EN
    tlast_err_n = tlast_err;
`endif
    case (state)
      IDLE: begin
        if (go) begin
          state_n  = SEND_A;
          tx_idx_n = '0;
          tvalid_n = 1'b1;
          tdata_n  = mem_a[0];
          tlast_n  = 1'b0;
          sel_n    = 1'b0;
          busy_n   = 1'b1;
`ifdef MAT_HOST_TLAST_CHECK_EN
          tlast_err_n = 1'b0;
`endif
        end
      end
      SEND_A: begin
        if (tx_hs_c) begin
          if (tx_idx == LAST_IDX) begin
            // A -> B with no bubble; sel flips together with the first B beat
            state_n  = SEND_B;
            tx_idx_n = '0;
            tdata_n  = mem_b[0];
            tlast_n  = 1'b0;
            sel_n    = 1'b1;
          end else begin
            tx_idx_n = tx_nxt;
            tdata_n  = mem_a[tx_nxt];
            tlast_n  = (tx_nxt == LAST_IDX);
          end
        end
      end
      SEND_B: begin
        if (tx_hs_c) begin
          if (tx_idx == LAST_IDX) begin
            state_n  = START;
            tx_idx_n = '0;
            tvalid_n = 1'b0;
            tlast_n  = 1'b0;
            start_n  = 1'b1;
          end else begin
            tx_idx_n = tx_nxt;
            tdata_n  = mem_b[tx_nxt];
            tlast_n  = (tx_nxt == LAST_IDX);
          end
        end
      end
      START: begin
        state_n    = RECV;
        s_tready_n = 1'b1;
      end
      RECV: begin
        if (s00_axis_tvalid) begin
          rx_we_c = 1'b1;
`ifdef MAT_HOST_TLAST_CHECK_EN
          if (s00_axis_tlast != (rx_idx == LAST_IDX)) tlast_err_n = 1'b1;
`endif
          if (rx_idx == LAST_IDX) begin
            state_n    = DONE;
            rx_idx_n   = '0;
            s_tready_n = 1'b0;
            done_n     = 1'b1;
          end else begin
            rx_idx_n = rx_idx + SIZE_LOG'(1);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        sel_n   = 1'b0;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      state           <= IDLE;
      tx_idx          <= '0;
      rx_idx          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      start           <= 1'b0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tlast  <= 1'b0;
      sel             <= 1'b0;
      s00_axis_tready <= 1'b0;
`ifdef MAT_HOST_TLAST_CHECK_EN
      tlast_err       <= 1'b0;
`endif
    end else begin
      state           <= state_n;
      tx_idx          <= tx_idx_n;
      rx_idx          <= rx_idx_n;
      busy            <= busy_n;
      done            <= done_n;
      start           <= start_n;
      m00_axis_tvalid <= tvalid_n;
      m00_axis_tdata  <= tdata_n;
      m00_axis_tlast  <= tlast_n;
      sel             <= sel_n;
      s00_axis_tready <= s_tready_n;
`ifdef MAT_HOST_TLAST_CHECK_EN
      tlast_err       <= tlast_err_n;
`endif
    end
  end

  // Operand RAM writes, accepted only while idle.
  always_ff @(posedge s00_axi_aclk) begin
    if (state == IDLE && load_we) begin
      if (load_sel) mem_b[load_addr] <= load_data;
      else          mem_a[load_addr] <= load_data;
    end
  end

  // Result RAM capture.
  always_ff @(posedge s00_axi_aclk) begin
    if (rx_we_c) mem_r[rx_idx] <= s00_axis_tdata;
  end

  // Readback port, independent of the run state.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) rd_data <= '0;
    else                rd_data <= mem_r[rd_addr];
  end

endmodule

// File: tb/tb_mat_stream_host.sv
// Self-checking bench for mat_stream_host with a behavioural accelerator
// model on the far side of both streams.
`timescale 1ns/1ps
module tb_mat_stream_host;
  localparam int DIM_LOG  = 1;
  localparam int DIM      = 2;
  localparam int SIZE     = 4;
  localparam int SIZE_LOG = 2;
  localparam int DW       = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                load_we = 1'b0;
  logic                load_sel = 1'b0;
  logic [SIZE_LOG-1:0] load_addr = '0;
  logic [DW-1:0]       load_data = '0;
  logic                go = 1'b0;
  logic                busy, done, tlast_err;
  logic                m_tvalid, m_tlast;
  logic [DW-1:0]       m_tdata;
  logic [DW/8-1:0]     m_tstrb;
  logic                m_tready = 1'b1;
  logic                sel, start, s_tready;
  logic [DW-1:0]       s_tdata = '0;
  logic                s_tlast = 1'b0;
  logic                s_tvalid = 1'b0;
  logic [SIZE_LOG-1:0] rd_addr = '0;
  logic [DW-1:0]       rd_data;

  always #5 clk = ~clk;

  mat_stream_host #(.DIM_LOG(DIM_LOG), .DATA_WIDTH(DW)) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .load_we(load_we), .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data),
    .go(go), .busy(busy), .done(done), .tlast_err(tlast_err),
    .m00_axis_tvalid(m_tvalid), .m00_axis_tdata(m_tdata), .m00_axis_tstrb(m_tstrb),
    .m00_axis_tlast(m_tlast), .m00_axis_tready(m_tready),
    .sel(sel), .start(start),
    .s00_axis_tready(s_tready), .s00_axis_tdata(s_tdata), .s00_axis_tlast(s_tlast),
    .s00_axis_tvalid(s_tvalid),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [DW-1:0]       d;
    logic                last;
    logic                s;
    logic [SIZE_LOG-1:0] idx;
  } beat_t;

  logic [DW-1:0] sh_a [SIZE];
  logic [DW-1:0] sh_b [SIZE];
  beat_t         exp_q [$];

  function automatic logic [DW-1:0] dotp(input logic [DW-1:0] a [SIZE],
                                          input logic [DW-1:0] b [SIZE], input int n);
    logic [DW-1:0] s = '0;
    int r = n / DIM;
    int c = n % DIM;
    for (int k = 0; k < DIM; k++) s += a[r*DIM+k] * b[k*DIM+c];
    return s;
  endfunction

  // ---------------- compare process / accelerator sink ----------------
  int            cyc = 0;
  int            go_cyc = 0;
  logic          full_rate = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic          prev_last = 1'b0, prev_sel = 1'b0;
  logic          acc_adv = 1'b0, start_seen = 1'b0;
  int            rx_cnt = 0, last_rx_cyc = 0, done_cnt = 0, start_cnt = 0;
  logic          rx_done_valid = 1'b0;
  logic [DW-1:0] cap_a [SIZE];
  logic [DW-1:0] cap_b [SIZE];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    beat_t e;
    if (prev_stall) begin
      chk("stall_tvalid", 64'(m_tvalid), 64'd1);
      chk("stall_tdata", 64'(m_tdata), 64'(prev_d));
      chk("stall_tlast", 64'(m_tlast), 64'(prev_last));
      chk("stall_sel", 64'(sel), 64'(prev_sel));
    end
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) fail("unexpected_operand_beat");
      else begin
        e = exp_q.pop_front();
        chk("beat_data", 64'(m_tdata), 64'(e.d));
        chk("beat_last", 64'(m_tlast), 64'(e.last));
        chk("beat_sel", 64'(sel), 64'(e.s));
        if (e.s) cap_b[e.idx] = m_tdata;
        else     cap_a[e.idx] = m_tdata;
      end
    end
    prev_stall = !rst && m_tvalid && !m_tready;
    prev_d     = m_tdata;
    prev_last  = m_tlast;
    prev_sel   = sel;

    start_seen = start;
    if (start) begin
      start_cnt++;
      chk("start_after_all_beats", 64'(exp_q.size()), 64'd0);
      if (full_rate) chk("start_cycle", 64'(cyc - go_cyc), 64'(2*SIZE+1));
      rx_cnt = 0;
      rx_done_valid = 1'b0;
    end

    acc_adv = s_tvalid && s_tready;
    if (acc_adv) begin
      rx_cnt++;
      if (rx_cnt == SIZE) begin
        rx_done_valid = 1'b1;
        last_rx_cyc = cyc;
      end
    end

    if (done) begin
      done_cnt++;
      if (!rx_done_valid) fail("done_without_full_result");
      else chk("done_latency", 64'(cyc - last_rx_cyc), 64'd1);
      rx_done_valid = 1'b0;
    end
  end

  // Accelerator result source: multiplies captured operands, streams C back.
  int            acc_idx = 0;
  logic          acc_active = 1'b0, acc_hold = 1'b0;
  logic          acc_gap = 1'b0, acc_bad = 1'b0;
  logic [DW-1:0] acc_c [SIZE];

  always begin
    @(posedge clk); #1;
    if (rst) begin
      acc_active = 1'b0;
      acc_hold   = 1'b0;
    end else if (start_seen) begin
      for (int n = 0; n < SIZE; n++) acc_c[n] = dotp(cap_a, cap_b, n);
      acc_active = 1'b1;
      acc_idx    = 0;
      acc_hold   = acc_gap;
    end else if (acc_adv) begin
      acc_idx++;
      acc_hold = acc_gap;
      if (acc_idx >= SIZE) acc_active = 1'b0;
    end else begin
      acc_hold = 1'b0;
    end
    if (acc_active && !acc_hold) begin
      s_tvalid = 1'b1;
      s_tdata  = acc_c[acc_idx];
      s_tlast  = acc_bad ? (acc_idx == 2) : (acc_idx == SIZE-1);
    end else begin
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tlast  = 1'b0;
    end
  end

  // Operand-side ready: held high or toggling every cycle.
  logic bp_mode = 1'b0;
  always begin
    @(posedge clk); #1;
    m_tready = bp_mode ? !m_tready : 1'b1;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic s, input int a, input logic [DW-1:0] d);
    load_we = 1'b1; load_sel = s; load_addr = SIZE_LOG'(a); load_data = d;
    tick();
    load_we = 1'b0;
    if (s) sh_b[a] = d;
    else   sh_a[a] = d;
  endtask

  task automatic load_all(input logic [DW-1:0] a0, a1, a2, a3, b0, b1, b2, b3);
    load(1'b0, 0, a0); load(1'b0, 1, a1); load(1'b0, 2, a2); load(1'b0, 3, a3);
    load(1'b1, 0, b0); load(1'b1, 1, b1); load(1'b1, 2, b2); load(1'b1, 3, b3);
  endtask

  task automatic launch(input logic fr);
    beat_t b;
    for (int i = 0; i < SIZE; i++) begin
      b.d = sh_a[i]; b.last = (i == SIZE-1); b.s = 1'b0; b.idx = SIZE_LOG'(i);
      exp_q.push_back(b);
    end
    for (int i = 0; i < SIZE; i++) begin
      b.d = sh_b[i]; b.last = (i == SIZE-1); b.s = 1'b1; b.idx = SIZE_LOG'(i);
      exp_q.push_back(b);
    end
    full_rate = fr;
    go = 1'b1;
    go_cyc = cyc;
    tick();
    go = 1'b0;
    chk("c1_busy", 64'(busy), 64'd1);
    chk("c1_tvalid", 64'(m_tvalid), 64'd1);
    chk("c1_tdata", 64'(m_tdata), 64'(sh_a[0]));
    chk("c1_sel", 64'(sel), 64'd0);
    chk("c1_tlast_err", 64'(tlast_err), 64'd0);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if (done) seen = 1;
    end
    if (!seen) fail("done_timeout");
    else begin
      tick();
      chk("post_busy", 64'(busy), 64'd0);
      chk("post_sel", 64'(sel), 64'd0);
      chk("post_tvalid", 64'(m_tvalid), 64'd0);
      chk("post_s_tready", 64'(s_tready), 64'd0);
      chk("all_beats_seen", 64'(exp_q.size()), 64'd0);
    end
  endtask

  task automatic check_rb();
    for (int n = 0; n < SIZE; n++) begin
      rd_addr = SIZE_LOG'(n);
      tick();
      chk("rd_data", 64'(rd_data), 64'(dotp(sh_a, sh_b, n)));
    end
  endtask

  initial begin
    int dc;
    bit seen;
    rst = 1'b1;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_tlast_err", 64'(tlast_err), 64'd0);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    chk("rst_sel", 64'(sel), 64'd0);
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("tstrb", 64'(m_tstrb), 64'hF);
    rst = 1'b0;
    tick();

    // Basic run: [1 2;3 4] x [5 6;7 8] = [19 22;43 50]
    load_all(1, 2, 3, 4, 5, 6, 7, 8);
    chk("model_c0", 64'(dotp(sh_a, sh_b, 0)), 64'd19);
    chk("model_c1", 64'(dotp(sh_a, sh_b, 1)), 64'd22);
    chk("model_c2", 64'(dotp(sh_a, sh_b, 2)), 64'd43);
    chk("model_c3", 64'(dotp(sh_a, sh_b, 3)), 64'd50);
    launch(1'b1);
    wait_done();
    check_rb();
    rd_addr = SIZE_LOG'(3);
    tick();
    chk("basic_rd3_literal", 64'(rd_data), 64'd50);
    chk("basic_tlast_err", 64'(tlast_err), 64'd0);
    chk("basic_start_cnt", 64'(start_cnt), 64'd1);
    chk("basic_done_cnt", 64'(done_cnt), 64'd1);

    // Backpressure on both streams with different operands
    load_all(3, 1, 4, 1, 5, 9, 2, 32'hFFFF_FFFF);
    bp_mode = 1'b1; acc_gap = 1'b1;
    launch(1'b0);
    wait_done();
    bp_mode = 1'b0; acc_gap = 1'b0;
    check_rb();

    // go and load_we during RECV are ignored
    load_all(1, 2, 3, 4, 5, 6, 7, 8);
    launch(1'b1);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (s_tready) seen = 1;
    end
    if (!seen) fail("recv_timeout");
    go = 1'b1; load_we = 1'b1; load_sel = 1'b0; load_addr = '0; load_data = 32'd99;
    tick();
    go = 1'b0; load_we = 1'b0;
    dc = done_cnt;
    wait_done();
    chk("recv_done_once", 64'(done_cnt - dc), 64'd1);
    tick(); tick();
    chk("no_restart_tvalid", 64'(m_tvalid), 64'd0);
    chk("no_restart_busy", 64'(busy), 64'd0);
    check_rb();
    launch(1'b1);
    chk("a0_kept_literal", 64'(m_tdata), 64'd1);
    wait_done();
    check_rb();

    // Reset during SEND_B at index 1
    launch(1'b1);
    repeat (5) tick();
    chk("pre_rst_tdata", 64'(m_tdata), 64'(sh_b[1]));
    chk("pre_rst_sel", 64'(sel), 64'd1);
    rst = 1'b1;
    tick();
    chk("rst_mid_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_mid_sel", 64'(sel), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    dc = done_cnt;
    repeat (20) tick();
    chk("rst_no_done", 64'(done_cnt), 64'(dc));
    launch(1'b1);
    wait_done();
    check_rb();

    // Result framing error: tlast on beat 2 instead of beat 3
    acc_bad = 1'b1;
    dc = done_cnt;
    launch(1'b1);
    wait_done();
    acc_bad = 1'b0;
    chk("framing_done", 64'(done_cnt - dc), 64'd1);
`ifdef MAT_HOST_TLAST_CHECK_EN
    chk("framing_tlast_err", 64'(tlast_err), 64'd1);
`else
    chk("framing_tlast_err_off", 64'(tlast_err), 64'd0);
`endif
    check_rb();
    launch(1'b1);
    wait_done();
    chk("clean_tlast_err", 64'(tlast_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mat_stream_host.md
# mat_stream_host

Host-side stream engine for the matrix-multiply accelerator. It holds operand matrices A and B in local BRAM and streams them to the accelerator's AXI-Stream slave, driving `sel` to pick the matrix. It then pulses `start` and captures the result matrix from the accelerator's AXI-Stream master into a local result BRAM, which a readback port exposes. It sits between a PS/testbench-side load port and the accelerator, implementing the opposite end of both of the accelerator's stream interfaces.

## Interface
- `DIM_LOG`, 1: log2 of the matrix dimension.
- `DIM`, 2**DIM_LOG: matrix dimension.
- `SIZE`, DIM*DIM: elements per matrix.
- `SIZE_LOG`, 2*DIM_LOG: element address width.
- `DATA_WIDTH`, 32: element width.

Ports:
- `s00_axi_aclk` in 1: the single clock.
- `s00_axi_areset` in 1: reset, synchronous, active-high.
- `load_we` in 1: write strobe into the operand BRAM.
- `load_sel` in 1: operand select for the write, 0 = A, 1 = B.
- `load_addr` in SIZE_LOG: operand write address.
- `load_data` in DATA_WIDTH: operand write data.
- `go` in 1: starts one complete run.
- `busy` out 1: high from the cycle after `go` is accepted until `done`.
- `done` out 1: one-cycle pulse when the result capture completes.
- `tlast_err` out 1: sticky flag for result-stream framing errors.
- `m00_axis_tvalid` out 1: operand stream valid.
- `m00_axis_tdata` out DATA_WIDTH: operand stream data.
- `m00_axis_tstrb` out DATA_WIDTH/8: operand byte strobes, always all ones.
- `m00_axis_tlast` out 1: operand stream last beat.
- `m00_axis_tready` in 1: operand stream ready from the accelerator.
- `sel` out 1: matrix select to the accelerator.
- `start` out 1: multiply start pulse to the accelerator.
- `s00_axis_tready` out 1: result stream ready.
- `s00_axis_tdata` in DATA_WIDTH: result stream data.
- `s00_axis_tlast` in 1: result stream last beat.
- `s00_axis_tvalid` in 1: result stream valid.
- `rd_addr` in SIZE_LOG: result readback address.
- `rd_data` out DATA_WIDTH: result readback data, registered, 1-cycle latency.

## Operation
- FSM states: IDLE, SEND_A, SEND_B, START, RECV, DONE.
- IDLE:
  - `load_we` writes `mem_A` or `mem_B`; `load_we` is ignored in every other state.
  - When `go` is high, the block loads `tdata` with A[0] and sets `tvalid`. The next state is SEND_A.
- SEND_A and SEND_B:
  - An element index counts handshakes (`tvalid && tready`).
  - On each handshake at index i < SIZE-1, `tdata` loads the next element of the same matrix.
  - `m00_axis_tlast` is high exactly while the index is SIZE-1.
  - On the last handshake in SEND_A, `tdata` loads B[0], the index wraps to 0, `sel` is set to 1, and the next state is SEND_B. `tvalid` stays high, so there is no bubble between A and B.
  - On the last handshake in SEND_B, `tvalid` and `tlast` clear and the next state is START.
- `sel` is 0 from IDLE through SEND_A. It is 1 from SEND_B through DONE, so it is stable on every beat of each matrix. It returns to 0 in IDLE.
- START: `start` is high for exactly this one cycle. The next state is RECV.
- RECV:
  - `s00_axis_tready` is 1.
  - Each beat with `s00_axis_tvalid` high writes `mem_R[rx_idx]` and increments `rx_idx`.
  - The beat at `rx_idx` = SIZE-1 moves the state to DONE.
  - `s00_axis_tvalid` while not in RECV is ignored and `tready` is 0.
- DONE: `done` is high for 1 cycle. The next state is IDLE.
- `go` outside IDLE is ignored.
- The readback port is always active: `rd_data <= mem_R[rd_addr]`, independent of the FSM.
- Address arithmetic is modulo 2^SIZE_LOG; counters never exceed SIZE-1.

## Timing
- Reset, effective on the next clock edge, sets:
  - state = IDLE;
  - `busy`, `done`, `tlast_err`, `m00_axis_tvalid`, `m00_axis_tlast`, `sel`, `start`, `s00_axis_tready` = 0;
  - `m00_axis_tdata` = 0 and `rd_data` = 0;
  - all counters = 0.
- BRAM contents are not cleared by reset.
- Reset mid-run aborts the run immediately, with no `done` pulse.
- `go` is sampled at cycle 0. `tvalid` is high with A[0] at cycle 1 and `busy` is high at cycle 1.
- With `tready` held at 1:
  - the beats occupy cycles 1..2·SIZE;
  - `start` is high at cycle 2·SIZE+1;
  - RECV begins at cycle 2·SIZE+2.
- `done` follows the final result beat by exactly 1 cycle.
- While `tready` = 0, `tdata`, `tlast` and `sel` hold their values.
- `tvalid` never drops before a handshake.

## Configuration
- With `MAT_HOST_TLAST_CHECK_EN` defined:
  - `tlast_err` is set if `s00_axis_tlast` is high on a beat with `rx_idx` ≠ SIZE-1.
  - `tlast_err` is also set if `s00_axis_tlast` is low on the beat at `rx_idx` = SIZE-1.
  - Once set, it stays set until the next accepted `go` or reset.
  - Termination of RECV is count-based either way.
- Without the macro, `tlast_err` is constant 0, no check logic is built, and `s00_axis_tlast` is ignored.

## Test plan
- Basic run, DIM_LOG=1, A={1,2,3,4}, B={5,6,7,8}, `tready`=1, accelerator attached:
  - operand beats are 1,2,3,4 with `sel`=0, then 5,6,7,8 with `sel`=1;
  - `tlast` is high on the 4th and 8th beats, `start` at cycle 9;
  - `rd_data` reads back {19,22,43,50} after `done`.
- Backpressure, `m00_axis_tready` toggling every cycle: the same 8-beat sequence arrives with no duplicate or dropped beat, and `tdata` is stable during every stall.
- Framing error, with the macro on: a result stream of 4 beats with `tlast` on beat index 2 gives `tlast_err`=1, `done` still pulses after the 4th beat, and `mem_R` holds all 4 values.
- Reset during SEND_B at index 1: on the next cycle `tvalid`=`sel`=`busy`=0 and there is no `done`. A new `go` restarts streaming from A[0].
- Ignored inputs during RECV:
  - `go` pulsed: no effect on the state sequence;
  - `load_we` to A[0]=99: A[0] still reads as 1 on the next run.
